// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA timing defaults, derived constants, FSM state and window helper
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vga_state_e;

    // Half-open window test: lo <= v < hi
    function automatic logic in_range(input logic [CNT_W-1:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster coordinate/sync bundle from the timing generator to renderers
interface vga_timing_gen_if #(
    parameter int FRAME_CNT_W = 8
);
    logic [9:0]             DrawX;
    logic [9:0]             DrawY;
    logic                   blank;
    logic                   hs;
    logic                   vs;
    logic                   line_start;
    logic                   frame_start;
    logic [FRAME_CNT_W-1:0] frame_count;

    modport master (
        output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );

    modport slave (
        input DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_sync_delay.sv
// rtl/vga_sync_delay.sv - parameterized-depth shift register with per-bit reset values
module vga_sync_delay #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= RST_VAL;
            end
        end else begin
            r_pipe[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator; VGA_SYNC_ALIGN_EN delays hs/vs/frame_start by SYNC_DELAY
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int SYNC_DELAY  = 1,
    parameter int FRAME_CNT_W = 8
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    vga_timing_gen_if.master  o_vga
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    vga_state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_hc, r_vc, w_hc_nxt, w_vc_nxt;
    logic                   w_frame_wrap;
    logic                   r_hs, r_vs;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic                   w_run, w_frame_start;

    always_comb begin
        w_state_nxt  = r_state;
        w_hc_nxt     = r_hc;
        w_vc_nxt     = r_vc;
        w_frame_wrap = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_RUN;
                w_hc_nxt    = '0;
                w_vc_nxt    = '0;
            end
            ST_RUN: begin
                if (r_hc == H_LAST) begin
                    w_hc_nxt = '0;
                    if (r_vc == V_LAST) begin
                        w_vc_nxt     = '0;
                        w_frame_wrap = 1'b1;
                    end else begin
                        w_vc_nxt = r_vc + 1'b1;
                    end
                end else begin
                    w_hc_nxt = r_hc + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Syncs decode the next-state counters so the registered level lines up with hc/vc
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_hc        <= '0;
            r_vc        <= '0;
            r_hs        <= 1'b1;
            r_vs        <= 1'b1;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hc    <= w_hc_nxt;
            r_vc    <= w_vc_nxt;
            r_hs    <= !in_range(w_hc_nxt, HS_START, HS_END);
            r_vs    <= !in_range(w_vc_nxt, VS_START, VS_END);
            if (w_frame_wrap) begin
                r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

    assign w_run         = (r_state == ST_RUN);
    assign w_frame_start = w_run && (r_hc == '0) && (r_vc == '0);

    assign o_vga.DrawX       = r_hc;
    assign o_vga.DrawY       = r_vc;
    assign o_vga.blank       = w_run && in_range(r_hc, 0, H_ACTIVE) && in_range(r_vc, 0, V_ACTIVE);
    assign o_vga.line_start  = w_run && (r_hc == '0);
    assign o_vga.frame_count = r_frame_cnt;

`ifdef VGA_SYNC_ALIGN_EN
    logic [2:0] w_sync_dly;

    vga_sync_delay #(
        .WIDTH   (3),
        .DEPTH   (SYNC_DELAY),
        .RST_VAL (3'b110)
    ) u_sync_delay (
        .i_clk   (vga_clk),
        .i_rst_n (reset_n),
        .i_data  ({r_hs, r_vs, w_frame_start}),
        .o_data  (w_sync_dly)
    );

    assign o_vga.hs          = w_sync_dly[2];
    assign o_vga.vs          = w_sync_dly[1];
    assign o_vga.frame_start = w_sync_dly[0];
`else
    logic w_unused_sync_delay;
    assign w_unused_sync_delay = (SYNC_DELAY != 0);

    assign o_vga.hs          = r_hs;
    assign o_vga.vs          = r_vs;
    assign o_vga.frame_start = w_frame_start;
`endif

endmodule
